ifm_addr_reader: RTL and testbench

- Read-side counterpart of the OFM write address generator.
- Walks the input feature map in the same traversal order the OFM writer uses: column strips of width ≤ SYSTOLIC_SIZE, one output row per window, rows top-to-bottom, then the next strip.
- For each window it issues, per channel, KERNEL_SIZE row-segment read requests (start address and length) to the IFM buffer that feeds the systolic array.
- IFM is stored pre-padded and channel-major: addr = c*IFM_SIZE*IFM_SIZE + row*IFM_SIZE + col. Convolution stride is 1.

---
 rtl/ifm_rd_pkg.sv | 23 ++
 rtl/ifm_tile_cursor.sv | 60 ++++++
 rtl/ifm_addr_reader.sv | 135 +++++++++++++
 tb/tb_ifm_addr_reader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ifm_rd_pkg.sv
// Shared constants and helpers for the IFM read address reader.
package ifm_rd_pkg;

    localparam int LEN_W  = 6;
    localparam int TILE_W = 5;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_ADVANCE = 2'd2;

    function automatic int ofm_size(input int ifm_size, input int kernel_size);
        return ifm_size - kernel_size + 1;
    endfunction

    function automatic int plane(input int ifm_size);
        return ifm_size * ifm_size;
    endfunction

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/ifm_tile_cursor.sv
// Tracks the current window position (row, strip column) and the width of the
// current column strip; steps once per advance pulse.
module ifm_tile_cursor
    import ifm_rd_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int IFM_SIZE      = 34,
    parameter int KERNEL_SIZE   = 3,
    parameter int ADDR_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] row,
    output logic [ADDR_WIDTH-1:0] strip_col,
    output logic [TILE_W-1:0]     tile_w,
    output logic [LEN_W-1:0]      rd_len,
    output logic                  frame_last
);

    localparam int OFM      = ofm_size(IFM_SIZE, KERNEL_SIZE);
    localparam int TILE_RST = min_int(SYSTOLIC_SIZE, OFM);
    localparam logic [ADDR_WIDTH-1:0] OFM_A  = ADDR_WIDTH'(OFM);
    localparam logic [ADDR_WIDTH-1:0] SS_A   = ADDR_WIDTH'(SYSTOLIC_SIZE);
    localparam logic [ADDR_WIDTH-1:0] HALO_A = ADDR_WIDTH'(KERNEL_SIZE - 1);

    logic [ADDR_WIDTH-1:0] strip_end;
    logic [ADDR_WIDTH-1:0] strip_n;
    logic [ADDR_WIDTH-1:0] rem_n;
    logic [ADDR_WIDTH-1:0] tile_n;
    logic                  row_last;

    always_comb begin
        strip_end  = strip_col + ADDR_WIDTH'(tile_w);
        row_last   = (row == OFM_A - 1'b1);
        frame_last = row_last && (strip_end >= OFM_A);
        strip_n    = strip_col;
        if (row_last) begin
            strip_n = (strip_end >= OFM_A) ? '0 : strip_end;
        end
        // last strip may be narrower than the array
        rem_n  = OFM_A - strip_n;
        tile_n = (rem_n < SS_A) ? rem_n : SS_A;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row       <= '0;
            strip_col <= '0;
            tile_w    <= TILE_W'(TILE_RST);
            rd_len    <= LEN_W'(TILE_RST + KERNEL_SIZE - 1);
        end else if (advance) begin
            row       <= row_last ? '0 : row + 1'b1;
            strip_col <= strip_n;
            tile_w    <= TILE_W'(tile_n);
            rd_len    <= LEN_W'(tile_n + HALO_A);
        end
    end

endmodule

// File: rtl/ifm_addr_reader.sv
// Issues KERNEL_SIZE row-segment reads per channel for each output window,
// walking the IFM in the same strip/row order as the OFM writer.
//   state   | meaning
//   IDLE    | waiting for start
//   ISSUE   | presenting read requests, advancing c/kr on handshake
//   ADVANCE | window finished, cursor steps to the next window
module ifm_addr_reader
    import ifm_rd_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int IFM_SIZE      = 34,
    parameter int KERNEL_SIZE   = 3,
    parameter int ADDR_WIDTH    = 16,
    parameter int MAX_CHANNEL   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [5:0]            num_channel,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [LEN_W-1:0]      rd_len,
    output logic [TILE_W-1:0]     tile_w,
    output logic                  busy,
    output logic                  window_done,
    output logic                  frame_done
);

    localparam logic [ADDR_WIDTH-1:0] IFM_A   = ADDR_WIDTH'(IFM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] PLANE_A = ADDR_WIDTH'(plane(IFM_SIZE));
    localparam logic [1:0]            KR_LAST = 2'(KERNEL_SIZE - 1);
    localparam logic [5:0]            NCH_MAX = 6'(MAX_CHANNEL);

    logic [1:0]            state;
    logic [5:0]            nch;
    logic [5:0]            c;
    logic [1:0]            kr;
    logic [5:0]            c_n;
    logic [1:0]            kr_n;
    logic                  last_req;
    logic [ADDR_WIDTH-1:0] row;
    logic [ADDR_WIDTH-1:0] strip_col;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic                  frame_last;

    ifm_tile_cursor #(
        .SYSTOLIC_SIZE (SYSTOLIC_SIZE),
        .IFM_SIZE      (IFM_SIZE),
        .KERNEL_SIZE   (KERNEL_SIZE),
        .ADDR_WIDTH    (ADDR_WIDTH)
    ) u_cursor (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance    (state == ST_ADVANCE),
        .row        (row),
        .strip_col  (strip_col),
        .tile_w     (tile_w),
        .rd_len     (rd_len),
        .frame_last (frame_last)
    );

    always_comb begin
        last_req = (kr == KR_LAST) && (c == nch - 6'd1);
        if (kr == KR_LAST) begin
            kr_n = '0;
            c_n  = c + 6'd1;
        end else begin
            kr_n = kr + 2'd1;
            c_n  = c;
        end
        base   = row * IFM_A + strip_col;
        addr_n = base + ADDR_WIDTH'(c_n) * PLANE_A + ADDR_WIDTH'(kr_n) * IFM_A;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            nch         <= 6'd1;
            c           <= '0;
            kr          <= '0;
            rd_valid    <= 1'b0;
            rd_addr     <= '0;
            busy        <= 1'b0;
            window_done <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_ISSUE;
                        busy     <= 1'b1;
                        rd_valid <= 1'b1;
                        rd_addr  <= base;
                        c        <= '0;
                        kr       <= '0;
                        if (num_channel == 6'd0)
                            nch <= 6'd1;
                        else if (num_channel > NCH_MAX)
                            nch <= NCH_MAX;
                        else
                            nch <= num_channel;
                    end
                end
                ST_ISSUE: begin
                    if (rd_ready) begin
                        if (last_req) begin
                            state       <= ST_ADVANCE;
                            rd_valid    <= 1'b0;
                            window_done <= 1'b1;
                            frame_done  <= frame_last;
                        end else begin
                            c       <= c_n;
                            kr      <= kr_n;
                            rd_addr <= addr_n;
                        end
                    end
                end
                ST_ADVANCE: begin
                    state       <= ST_IDLE;
                    busy        <= 1'b0;
                    window_done <= 1'b0;
                    frame_done  <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    rd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifm_addr_reader.sv
// Directed bench: default config, a 22-wide IFM (narrow last strip) and a 1x1 kernel config.
module tb_ifm_addr_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst2_n = 1'b0;
    always #5 clk = ~clk;

    logic        s0 = 0, s1 = 0, s2 = 0;
    logic [5:0]  nc0 = 6'd2, nc1 = 6'd1, nc2 = 6'd3;
    logic        rr0 = 1, rr1 = 1, rr2 = 1;
    logic        v0, v1, v2, b0, b1, b2, w0, w1, w2, f0, f1, f2;
    logic [15:0] a0, a1, a2;
    logic [5:0]  l0, l1, l2;
    logic [4:0]  t0, t1, t2;

    int n_tests = 0;
    int n_fail  = 0;

    ifm_addr_reader u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(s0), .num_channel(nc0), .rd_ready(rr0),
        .rd_valid(v0), .rd_addr(a0), .rd_len(l0), .tile_w(t0), .busy(b0),
        .window_done(w0), .frame_done(f0)
    );

    ifm_addr_reader #(.IFM_SIZE(22)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1), .num_channel(nc1), .rd_ready(rr1),
        .rd_valid(v1), .rd_addr(a1), .rd_len(l1), .tile_w(t1), .busy(b1),
        .window_done(w1), .frame_done(f1)
    );

    ifm_addr_reader #(.IFM_SIZE(16), .KERNEL_SIZE(1)) u_dut2 (
        .clk(clk), .rst_n(rst2_n), .start(s2), .num_channel(nc2), .rd_ready(rr2),
        .rd_valid(v2), .rd_addr(a2), .rd_len(l2), .tile_w(t2), .busy(b2),
        .window_done(w2), .frame_done(f2)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // one 2-channel window on dut0, with hand-computed address list
    task automatic d0_burst(input string tag, input int e[6]);
        s0 = 1;
        @(negedge clk);
        s0 = 0;
        check({tag, "_len"}, int'(l0), 18);
        check({tag, "_tile"}, int'(t0), 16);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s_valid%0d", tag, i), int'(v0), 1);
            check($sformatf("%s_addr%0d", tag, i), int'(a0), e[i]);
            check($sformatf("%s_busy%0d", tag, i), int'(b0), 1);
            check($sformatf("%s_wd%0d", tag, i), int'(w0), 0);
            @(negedge clk);
        end
        check({tag, "_valid_end"}, int'(v0), 0);
        check({tag, "_wd"}, int'(w0), 1);
        check({tag, "_fd"}, int'(f0), 0);
        check({tag, "_busy_adv"}, int'(b0), 1);
        @(negedge clk);
        check({tag, "_busy_idle"}, int'(b0), 0);
        check({tag, "_wd_clear"}, int'(w0), 0);
    endtask

    task automatic d0_window(output int fa, output int tw, output int rl, output int fd);
        bit ok = 0;
        s0 = 1;
        @(negedge clk);
        s0 = 0;
        fa = int'(a0); tw = int'(t0); rl = int'(l0); fd = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (w0) begin fd = int'(f0); ok = 1; break; end
        end
        if (!ok) check("d0_window_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic d1_window(output int fa, output int tw, output int rl, output int fd);
        bit ok = 0;
        s1 = 1;
        @(negedge clk);
        s1 = 0;
        fa = int'(a1); tw = int'(t1); rl = int'(l1); fd = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (w1) begin fd = int'(f1); ok = 1; break; end
        end
        if (!ok) check("d1_window_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        int e1[6] = '{0, 34, 68, 1156, 1190, 1224};
        int e2[6] = '{34, 68, 102, 1190, 1224, 1258};
        int ebp[6] = '{0, 34, 68, 1156, 1190, 1224};
        int fa, tw, rl, fd;

        repeat (3) @(negedge clk);
        check("rst_valid", int'(v0), 0);
        check("rst_addr", int'(a0), 0);
        check("rst_len", int'(l0), 18);
        check("rst_tile", int'(t0), 16);
        check("rst_busy", int'(b0), 0);
        check("rst_wd", int'(w0), 0);
        check("rst_fd", int'(f0), 0);
        check("rst_k1_len", int'(l2), 16);
        rst_n = 1; rst2_n = 1;
        @(negedge clk);

        d0_burst("win1", e1);
        d0_burst("win2", e2);

        // backpressure on the 2nd request, with start pulses during ISSUE
        rst_n = 0; @(negedge clk); rst_n = 1; @(negedge clk);
        s0 = 1;
        @(negedge clk);
        s0 = 0;
        check("bp_addr0", int'(a0), ebp[0]);
        @(negedge clk);
        check("bp_addr1", int'(a0), ebp[1]);
        rr0 = 0; s0 = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold_valid%0d", i), int'(v0), 1);
            check($sformatf("bp_hold_addr%0d", i), int'(a0), 34);
        end
        rr0 = 1; s0 = 0;
        for (int i = 2; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("bp_addr%0d", i), int'(a0), ebp[i]);
            check($sformatf("bp_valid%0d", i), int'(v0), 1);
        end
        @(negedge clk);
        check("bp_wd", int'(w0), 1);
        @(negedge clk);
        check("bp_idle0", int'(b0), 0);
        @(negedge clk);
        check("bp_idle1", int'(b0), 0);
        check("bp_no_restart", int'(v0), 0);

        // strip wrap and frame end, one channel
        rst_n = 0; @(negedge clk); rst_n = 1; @(negedge clk);
        nc0 = 1;
        for (int w = 1; w <= 65; w++) begin
            d0_window(fa, tw, rl, fd);
            if (w == 1)  check("wrap_w1_addr", fa, 0);
            if (w == 2)  check("wrap_w2_addr", fa, 34);
            if (w == 32) begin check("wrap_w32_addr", fa, 31 * 34); check("wrap_w32_fd", fd, 0); end
            if (w == 33) begin
                check("wrap_w33_addr", fa, 16);
                check("wrap_w33_tile", tw, 16);
                check("wrap_w33_len", rl, 18);
            end
            if (w == 63) check("wrap_w63_fd", fd, 0);
            if (w == 64) check("wrap_w64_fd", fd, 1);
            if (w == 65) check("wrap_w65_addr", fa, 0);
        end

        // IFM 22: 20-wide OFM splits into strips of 16 and 4
        for (int w = 1; w <= 41; w++) begin
            d1_window(fa, tw, rl, fd);
            if (w == 20) begin check("i22_w20_tile", tw, 16); check("i22_w20_fd", fd, 0); end
            if (w == 21) begin
                check("i22_w21_addr", fa, 16);
                check("i22_w21_tile", tw, 4);
                check("i22_w21_len", rl, 6);
            end
            if (w == 22) check("i22_w22_addr", fa, 22 + 16);
            if (w == 39) check("i22_w39_fd", fd, 0);
            if (w == 40) check("i22_w40_fd", fd, 1);
            if (w == 41) begin check("i22_w41_addr", fa, 0); check("i22_w41_tile", tw, 16); end
        end

        // 1x1 kernel, 3 channels, then async reset mid-burst
        s2 = 1;
        @(negedge clk);
        s2 = 0;
        check("k1_addr0", int'(a2), 0);
        check("k1_len", int'(l2), 16);
        @(negedge clk);
        check("k1_addr1", int'(a2), 256);
        @(negedge clk);
        check("k1_addr2", int'(a2), 512);
        @(negedge clk);
        check("k1_wd", int'(w2), 1);
        check("k1_valid_end", int'(v2), 0);
        @(negedge clk);
        s2 = 1;
        @(negedge clk);
        s2 = 0;
        check("k1_w2_addr0", int'(a2), 16);
        @(negedge clk);
        check("k1_w2_addr1", int'(a2), 272);
        rst2_n = 0;
        #1;
        check("k1_rst_valid", int'(v2), 0);
        check("k1_rst_busy", int'(b2), 0);
        check("k1_rst_addr", int'(a2), 0);
        @(negedge clk);
        rst2_n = 1;
        @(negedge clk);
        s2 = 1;
        @(negedge clk);
        s2 = 0;
        check("k1_restart_addr", int'(a2), 0);
        check("k1_restart_valid", int'(v2), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
